// File: rtl/pbit_sampler_if.sv
// Probability request channel between the p-bit sampler and the sigmoid stage.
// The sampler is the master: it names the p-bit, the sigmoid stage answers.
interface pbit_sampler_if #(
    parameter int IDX_W = 4
);
    logic             prob_req;
    logic [IDX_W-1:0] idx;
    logic [15:0]      prob_in;
    logic             prob_valid;

    modport master (output prob_req, idx, input prob_in, prob_valid);
    modport slave  (input prob_req, idx, output prob_in, prob_valid);
endinterface

// File: rtl/pbit_sampler.sv
// Sequential p-bit update engine: walks every p-bit once per sweep and draws a
// new spin by comparing the sigmoid probability against a Galois LFSR sample.
module pbit_sampler #(
    parameter int          N_PBIT    = 16,
    parameter int          IDX_W     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [15:0]         sweeps,
    pbit_sampler_if.master      bus,
    output logic [N_PBIT-1:0]   spins,
    output logic                busy,
    output logic                done,
    output logic [15:0]         sweep_cnt,
    output logic [15:0]         flip_cnt
);
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [15:0]      SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PBIT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [15:0]      lfsr;
    logic [15:0]      sweeps_q;
    logic [IDX_W-1:0] idx_q;
    logic             req_q;

    logic             new_spin;
    logic             flip;
    logic [15:0]      lfsr_nxt;
    logic [15:0]      sweep_nxt;

    assign new_spin  = (lfsr <= bus.prob_in);
    assign flip      = new_spin ^ spins[idx_q];
    assign lfsr_nxt  = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign sweep_nxt = sweep_cnt + 16'd1;

    assign bus.prob_req = req_q;
    assign bus.idx      = idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            spins     <= '0;
            idx_q     <= '0;
            req_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sweep_cnt <= '0;
            flip_cnt  <= '0;
            sweeps_q  <= '0;
            lfsr      <= SEED;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Spins are deliberately kept so a new run warm-starts.
                    if (start) begin
                        state     <= RUN;
                        req_q     <= 1'b1;
                        busy      <= 1'b1;
                        idx_q     <= '0;
                        sweep_cnt <= '0;
                        flip_cnt  <= '0;
                        sweeps_q  <= sweeps;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= DONE;
                        req_q <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (bus.prob_valid) begin
                        spins[idx_q] <= new_spin;
                        lfsr         <= lfsr_nxt;
                        if (flip && flip_cnt != 16'hFFFF)
                            flip_cnt <= flip_cnt + 16'd1;
                        if (idx_q == LAST_IDX) begin
                            idx_q     <= '0;
                            sweep_cnt <= sweep_nxt;
                            // sweeps == 0 free-runs; sweep_cnt then wraps silently.
                            if (sweeps_q != 16'd0 && sweep_nxt == sweeps_q) begin
                                state <= DONE;
                                req_q <= 1'b0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pbit_sampler.sv
// Directed + randomized bench for pbit_sampler against a transaction-level model.
module tb_pbit_sampler;
    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst_n, start, stop;
    logic [15:0]   sweeps;
    logic [N-1:0]  spins;
    logic          busy, done;
    logic [15:0]   sweep_cnt, flip_cnt;

    pbit_sampler_if #(.IDX_W(4)) pif();

    pbit_sampler #(.N_PBIT(N), .IDX_W(4), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .sweeps(sweeps),
        .bus(pif), .spins(spins), .busy(busy), .done(done),
        .sweep_cnt(sweep_cnt), .flip_cnt(flip_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: phase 0 idle, 1 running, 2 done-pulse cycle.
    int           m_phase;
    int           m_idx;
    logic [N-1:0] m_spins;
    logic [15:0]  m_lfsr, m_sweep, m_flip, m_sweeps;
    int           hs_cnt;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("spins",     32'(spins),        32'(m_spins));
        chk("idx",       32'(pif.idx),      32'(m_idx));
        chk("prob_req",  32'(pif.prob_req), 32'(m_phase == 1));
        chk("busy",      32'(busy),         32'(m_phase == 1));
        chk("done",      32'(done),         32'(m_phase == 2));
        chk("sweep_cnt", 32'(sweep_cnt),    32'(m_sweep));
        chk("flip_cnt",  32'(flip_cnt),     32'(m_flip));
    endtask

    // One clock: apply inputs, predict the edge, sample 1ns after it.
    task automatic step(input bit st, input bit sp, input bit pv, input logic [15:0] pr);
        bit ns;
        start = st; stop = sp; pif.prob_valid = pv; pif.prob_in = pr;
        case (m_phase)
            0: if (st) begin
                m_phase = 1; m_idx = 0; m_sweep = 0; m_flip = 0; m_sweeps = sweeps;
            end
            1: if (sp) m_phase = 2;
               else if (pv) begin
                   hs_cnt++;
                   ns = (m_lfsr <= pr);
                   if (ns != m_spins[m_idx] && m_flip != 16'hFFFF) m_flip++;
                   m_spins[m_idx] = ns;
                   m_lfsr = lfsr_adv(m_lfsr);
                   m_idx++;
                   if (m_idx == N) begin
                       m_idx = 0;
                       m_sweep++;
                       if (m_sweeps != 0 && m_sweep == m_sweeps) m_phase = 2;
                   end
               end
            default: m_phase = 0;
        endcase
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        m_phase = 0; m_idx = 0; m_spins = '0; m_lfsr = 16'hACE1; m_sweep = 0; m_flip = 0;
        check_all();
        @(negedge clk);
        rst_n = 1'b1; start = 0; stop = 0; pif.prob_valid = 0; pif.prob_in = 0;
        @(posedge clk); #1;
        check_all();
    endtask

    initial begin
        logic [N-1:0] saved;
        int c, done_seen;
        rst_n = 1'b1; start = 0; stop = 0; sweeps = 0;
        pif.prob_valid = 0; pif.prob_in = 0;
        m_sweeps = 0; hs_cnt = 0;
        do_reset();

        // prob 0 never fires: all spins 0, no flips
        sweeps = 16'd1;
        step(1, 0, 1, 16'h0000);
        for (int i = 0; i < N; i++) step(0, 0, 1, 16'h0000);
        chk("p0_spins", 32'(spins), 32'h0);
        chk("p0_flip",  32'(flip_cnt), 32'h0);
        chk("p0_done",  32'(done), 32'h1);
        step(0, 0, 0, 0);

        // prob FFFF always fires; done exactly once, 17 edges after start
        step(1, 0, 1, 16'hFFFF);
        done_seen = 0;
        for (int i = 1; i <= 18; i++) begin
            step(0, 0, 1, 16'hFFFF);
            if (done) begin
                done_seen++;
                chk("p1_done_edge", 32'(i), 32'd16);
            end
        end
        chk("p1_spins", 32'(spins), 32'hFFFF);
        chk("p1_flip",  32'(flip_cnt), 32'd16);
        chk("p1_sweep", 32'(sweep_cnt), 32'd1);
        chk("p1_done_cnt", 32'(done_seen), 32'd1);

        // stalled upstream; start+stop together in IDLE: start wins; sweeps latched
        sweeps = 16'd2;
        step(1, 1, 0, 16'h0);
        sweeps = 16'($urandom);
        hs_cnt = 0;
        c = 0;
        while (m_phase == 1 && c < 300) begin
            step(1'($urandom), 0, (c % 3) == 2, 16'($urandom));
            c++;
        end
        chk("stall_timeout", 32'(c < 300), 32'd1);
        chk("stall_hs",    32'(hs_cnt), 32'd32);
        chk("stall_sweep", 32'(sweep_cnt), 32'd2);
        chk("stall_done",  32'(done), 32'd1);
        step(1, 0, 1, 16'h0);    // start during DONE is ignored
        step(0, 0, 0, 16'h0);

        // abort at idx 5 of sweep 3 in free-run
        sweeps = 16'd0;
        step(1, 0, 0, 16'h0);
        c = 0;
        while (!(m_idx == 5 && m_sweep == 3) && c < 400) begin
            step(0, 0, 1'($urandom), 16'($urandom));
            c++;
        end
        chk("abort_timeout", 32'(c < 400), 32'd1);
        saved = spins;
        step(0, 1, 1, 16'hFFFF);
        chk("abort_idx",   32'(pif.idx), 32'd5);
        chk("abort_sweep", 32'(sweep_cnt), 32'd3);
        chk("abort_spins", 32'(spins), 32'(saved));
        chk("abort_done",  32'(done), 32'd1);
        step(0, 0, 1, 16'hFFFF);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        step(1, 0, 0, 16'h0);
        chk("restart_idx",   32'(pif.idx), 32'd0);
        chk("restart_spins", 32'(spins), 32'(saved));

        // reset mid-run at idx 9 of sweep 1
        c = 0;
        while (!(m_idx == 9 && m_sweep == 1) && c < 400) begin
            step(0, 0, 1'($urandom), 16'($urandom));
            c++;
        end
        chk("rst_timeout", 32'(c < 400), 32'd1);
        do_reset();
        step(0, 0, 0, 16'h0);

        // first draws after reset: rnd 0xACE1 then 0xE270
        sweeps = 16'd1;
        step(1, 0, 0, 16'h0);
        step(0, 0, 1, 16'hACE1);
        chk("rnd0_eq", 32'(spins[0]), 32'd1);
        step(0, 0, 1, 16'hE26F);
        chk("rnd1_lo", 32'(spins[1]), 32'd0);
        do_reset();
        step(1, 0, 0, 16'h0);
        step(0, 0, 1, 16'hACE0);
        chk("rnd0_lo", 32'(spins[0]), 32'd0);
        step(0, 0, 1, 16'hE270);
        chk("rnd1_eq", 32'(spins[1]), 32'd1);
        c = 0;
        while (m_phase == 1 && c < 200) begin
            step(0, 0, 1'($urandom), 16'($urandom));
            c++;
        end
        chk("tail_timeout", 32'(c < 200), 32'd1);
        step(0, 0, 0, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
